// File: rtl/gnn_weight_axi_read_master_if.sv
// AXI4 read channels (AR/R) plus the beat stream toward the weight loader.
// Handshake rule for every channel: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface gnn_weight_axi_read_master_if #(
  parameter int AW = 64,
  parameter int DW = 512
);
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          data_tvalid;
  logic          data_tready;
  logic          data_tlast;
  logic [DW-1:0] data_tdata;

  modport master (
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
    output data_tvalid, data_tlast, data_tdata,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, data_tready
  );

  modport slave (
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
    input  data_tvalid, data_tlast, data_tdata,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast, data_tready
  );
endinterface

// File: rtl/gnn_weight_axi_read_master.sv
// AXI4 read master: splits one DRAM request into 4 KB-safe INCR bursts with an
// outstanding-burst cap and passes R beats straight through to the loader stream.
module gnn_weight_axi_read_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST_LEN    = 64,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          read_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          read_done,
  output logic                          busy,
  output logic [1:0]                    fsm_state,
  gnn_weight_axi_read_master_if.master  bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_XFER_SIZE_WIDTH;
  localparam int BW = SW - 5;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [SW:0]   size_plus;
  logic [BW-1:0] total_beats, ar_beats_left, r_beats_left;
  logic [BW-1:0] src_beats, page_room, cap_len, burst_len;
  logic [AW-1:0] addr_q, src_addr, araddr_q;
  logic [7:0]    arlen_q;
  logic          arvalid_q;
  logic [4:0]    outstanding;
  logic          start_ok, in_run, ar_issue, ar_hs, r_hs, r_final;
  logic          unused_bits;

  assign size_plus   = {1'b0, dram_xfer_size_in_bytes} + (SW+1)'(63);
  assign total_beats = size_plus[SW:6];
  assign unused_bits = ^{dram_xfer_start_addr[5:0], size_plus[5:0]};

  assign start_ok = (state == IDLE) && read_start;
  assign in_run   = (state == RUN);

  // In IDLE the first burst is sized from the raw request so AR can go out the very next cycle.
  assign src_addr  = (state == IDLE) ? {dram_xfer_start_addr[AW-1:6], 6'b0} : addr_q;
  assign src_beats = (state == IDLE) ? total_beats : ar_beats_left;
  assign page_room = BW'(7'd64 - {1'b0, src_addr[11:6]});
  assign cap_len   = (src_beats < BW'(C_MAX_BURST_LEN)) ? src_beats : BW'(C_MAX_BURST_LEN);
  assign burst_len = (cap_len < page_room) ? cap_len : page_room;

  assign ar_issue = (start_ok && (total_beats != '0)) ||
                    (in_run && !arvalid_q && (ar_beats_left != '0) &&
                     (outstanding < 5'(C_MAX_OUTSTANDING)));
  assign ar_hs    = arvalid_q && bus.m_axi_arready;
  assign r_hs     = bus.m_axi_rvalid && bus.m_axi_rready;
  assign r_final  = r_hs && (r_beats_left == BW'(1));

  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = arlen_q;
  assign bus.data_tvalid   = bus.m_axi_rvalid && in_run;
  assign bus.m_axi_rready  = bus.data_tready && in_run;
  assign bus.data_tdata    = bus.m_axi_rdata;
  assign bus.data_tlast    = bus.data_tvalid && (r_beats_left == BW'(1));
  assign fsm_state         = state;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    read_done = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (read_start) state_nxt = (total_beats != '0) ? RUN : DONE;
      end
      RUN:  if (r_final) state_nxt = DONE;
      DONE: begin
        read_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      addr_q        <= '0;
      ar_beats_left <= '0;
      r_beats_left  <= '0;
      outstanding   <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arlen_q       <= '0;
    end else begin
      if (start_ok) begin
        addr_q        <= src_addr;
        ar_beats_left <= total_beats;
        r_beats_left  <= total_beats;
        outstanding   <= '0;
      end else begin
        // The issued length is kept in arlen_q, so advance by that rather than recomputing.
        if (ar_hs) begin
          addr_q        <= addr_q + ((AW'(arlen_q) + AW'(1)) << 6);
          ar_beats_left <= ar_beats_left - (BW'(arlen_q) + BW'(1));
        end
        if (r_hs) r_beats_left <= r_beats_left - BW'(1);
        case ({ar_hs, r_hs && bus.m_axi_rlast})
          2'b10:   outstanding <= outstanding + 5'd1;
          2'b01:   outstanding <= outstanding - 5'd1;
          default: outstanding <= outstanding;
        endcase
      end
      if (ar_issue) begin
        arvalid_q <= 1'b1;
        araddr_q  <= src_addr;
        arlen_q   <= 8'(burst_len - BW'(1));
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_gnn_weight_axi_read_master.sv
// Directed bench: a memory model answers ARs, a monitor checks AR and stream beats
// against expected queues filled by the test sequence.
module tb_gnn_weight_axi_read_master;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int SW = 32;

  logic          kernel_clk = 1'b0;
  logic          kernel_rst;
  logic          read_start;
  logic [AW-1:0] start_addr;
  logic [SW-1:0] xfer_size;
  logic          read_done, busy;
  logic [1:0]    fsm_state;

  gnn_weight_axi_read_master_if #(.AW(AW), .DW(DW)) bus ();

  gnn_weight_axi_read_master dut (
    .kernel_clk              (kernel_clk),
    .kernel_rst              (kernel_rst),
    .read_start              (read_start),
    .dram_xfer_start_addr    (start_addr),
    .dram_xfer_size_in_bytes (xfer_size),
    .read_done               (read_done),
    .busy                    (busy),
    .fsm_state               (fsm_state),
    .bus                     (bus)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 kernel_clk = ~kernel_clk;

  int         total = 0;
  int         bad   = 0;
  longint     cyc   = 0;
  longint     last_beat_cyc = 0;
  longint     start_cyc = 0;
  int         beats_seen = 0;
  int         ar_seen = 0;
  bit         r_en;

  logic [71:0]   exp_ar_q[$];
  logic [DW:0]   exp_d_q[$];
  logic [64:0]   mem_q[$];

  always @(posedge kernel_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    return {8{a ^ 64'h5A5A_0000_C3C3_0000}};
  endfunction

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model (AXI slave) ----------------
  logic mem_ar_hs, mem_r_hs;
  initial begin
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = '0;
    bus.m_axi_rlast  = 1'b0;
    forever begin
      @(negedge kernel_clk);
      mem_ar_hs = bus.m_axi_arvalid && bus.m_axi_arready;
      mem_r_hs  = bus.m_axi_rvalid && bus.m_axi_rready;
      if (kernel_rst) mem_q.delete();
      else begin
        if (mem_r_hs) void'(mem_q.pop_front());
        if (mem_ar_hs)
          for (int j = 0; j <= int'(bus.m_axi_arlen); j++)
            mem_q.push_back({(j == int'(bus.m_axi_arlen)), bus.m_axi_araddr + 64'(64 * j)});
      end
      @(posedge kernel_clk);
      #1;
      if (r_en && (mem_q.size() > 0)) begin
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = pat(mem_q[0][63:0]);
        bus.m_axi_rlast  = mem_q[0][64];
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [71:0] ar_prev;
  bit          ar_wait = 1'b0;
  initial begin
    forever begin
      @(negedge kernel_clk);
      if (kernel_rst) ar_wait = 1'b0;
      else begin
        if (ar_wait)
          check("ar_stable", {bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arlen}, {1'b1, ar_prev});
        ar_wait = bus.m_axi_arvalid && !bus.m_axi_arready;
        ar_prev = {bus.m_axi_araddr, bus.m_axi_arlen};
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          ar_seen++;
          if (exp_ar_q.size() == 0) begin
            total++; bad++;
            $display("FAIL ar_unexpected act=%0h/%0d exp=none", bus.m_axi_araddr, bus.m_axi_arlen);
          end else check("ar", {bus.m_axi_araddr, bus.m_axi_arlen}, exp_ar_q.pop_front());
        end
        if (bus.data_tvalid && bus.data_tready) begin
          beats_seen++;
          check("rready_pass", bus.m_axi_rready, 1);
          if (exp_d_q.size() == 0) begin
            total++; bad++;
            $display("FAIL beat_unexpected act=%0h exp=none", bus.data_tdata[63:0]);
          end else check("beat", {bus.data_tlast, bus.data_tdata}, exp_d_q.pop_front());
          if (bus.data_tlast) last_beat_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_ar(input logic [63:0] a, input logic [7:0] len);
    exp_ar_q.push_back({a, len});
  endtask

  task automatic push_beats(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_d_q.push_back({(i == n - 1), pat(base + 64'(64 * i))});
  endtask

  task automatic start_xfer(input logic [63:0] a, input logic [31:0] s, input bit expect_ar);
    @(posedge kernel_clk); #1;
    start_addr = a; xfer_size = s; read_start = 1'b1;
    @(posedge kernel_clk); #1;
    read_start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", busy, 1);
    check("first_arvalid", bus.m_axi_arvalid, expect_ar);
  endtask

  task automatic wait_done(input bit zero_size);
    int     n = 0;
    bit     seen = 1'b0;
    longint dc = 0;
    while (!seen && n < 6000) begin
      @(negedge kernel_clk);
      n++;
      if (read_done) begin seen = 1'b1; dc = cyc; end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("done_timing", dc, zero_size ? start_cyc : last_beat_cyc + 1);
      check("busy_in_done", busy, 1);
      @(negedge kernel_clk);
      check("done_one_cycle", read_done, 0);
      check("busy_cleared", busy, 0);
    end
    check("ar_q_empty", exp_ar_q.size(), 0);
    check("beat_q_empty", exp_d_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  int          base_cnt, n;
  logic [DW-1:0] held;
  initial begin
    kernel_rst = 1'b1; read_start = 1'b0; start_addr = '0; xfer_size = '0;
    bus.m_axi_arready = 1'b1; bus.data_tready = 1'b1; r_en = 1'b1;
    repeat (3) @(posedge kernel_clk);
    #1;
    check("rst_read_done", read_done, 0);
    check("rst_busy", busy, 0);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_tlast", bus.data_tlast, 0);
    check("rst_araddr", bus.m_axi_araddr, 0);
    check("rst_arlen", bus.m_axi_arlen, 0);
    kernel_rst = 1'b0;

    // two beats, single burst
    push_ar(64'h0, 8'd1); push_beats(64'h0, 2);
    start_xfer(64'h0, 32'd128, 1'b1);
    wait_done(1'b0);

    // 8 KB: two full 4 KB bursts
    push_ar(64'h0, 8'd63); push_ar(64'h1000, 8'd63); push_beats(64'h0, 128);
    start_xfer(64'h0, 32'd8192, 1'b1);
    wait_done(1'b0);

    // 4 KB boundary split, with AR held off for a few cycles
    bus.m_axi_arready = 1'b0;
    push_ar(64'hFC0, 8'd0); push_ar(64'h1000, 8'd2); push_beats(64'hFC0, 4);
    start_xfer(64'hFC0, 32'd256, 1'b1);
    repeat (3) @(posedge kernel_clk);
    #1 bus.m_axi_arready = 1'b1;
    wait_done(1'b0);

    // unaligned start and partial final beat: 0x1010/100 B -> 2 beats from 0x1000
    push_ar(64'h1000, 8'd1); push_beats(64'h1000, 2);
    start_xfer(64'h1010, 32'd100, 1'b1);
    wait_done(1'b0);

    // zero size: no AR, done the cycle after start
    base_cnt = ar_seen;
    start_xfer(64'h40, 32'd0, 1'b0);
    wait_done(1'b1);
    check("zero_no_ar", ar_seen - base_cnt, 0);

    // outstanding cap with R withheld
    r_en = 1'b0;
    base_cnt = ar_seen;
    for (int i = 0; i < 16; i++) push_ar(64'(i) << 12, 8'd63);
    push_beats(64'h0, 1024);
    start_xfer(64'h0, 32'd65536, 1'b1);
    repeat (30) @(negedge kernel_clk);
    check("ar_outstanding_cap", ar_seen - base_cnt, 4);
    check("arvalid_held_low", bus.m_axi_arvalid, 0);
    r_en = 1'b1;
    wait_done(1'b0);

    // loader back-pressure for 5 cycles mid-burst
    push_ar(64'h2000, 8'd9); push_beats(64'h2000, 10);
    base_cnt = beats_seen;
    start_xfer(64'h2000, 32'd640, 1'b1);
    n = 0;
    while (beats_seen < base_cnt + 3 && n < 200) begin @(negedge kernel_clk); n++; end
    check("stall_reached", (beats_seen >= base_cnt + 3), 1);
    @(posedge kernel_clk); #1 bus.data_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge kernel_clk);
      check("stall_rready", bus.m_axi_rready, 0);
      if (k == 0) held = bus.data_tdata;
      else check("stall_tdata", bus.data_tdata, held);
    end
    @(posedge kernel_clk); #1 bus.data_tready = 1'b1;
    wait_done(1'b0);

    // reset in the middle of a run, then a normal transfer
    push_ar(64'h0, 8'd63); push_ar(64'h1000, 8'd63); push_beats(64'h0, 128);
    start_xfer(64'h0, 32'd8192, 1'b1);
    repeat (20) @(negedge kernel_clk);
    #1 kernel_rst = 1'b1;
    #1;
    check("midrst_arvalid", bus.m_axi_arvalid, 0);
    check("midrst_araddr", bus.m_axi_araddr, 0);
    check("midrst_arlen", bus.m_axi_arlen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_read_done", read_done, 0);
    check("midrst_tlast", bus.data_tlast, 0);
    check("midrst_tvalid", bus.data_tvalid, 0);
    exp_ar_q.delete(); exp_d_q.delete();
    repeat (2) @(posedge kernel_clk);
    #1 kernel_rst = 1'b0;
    push_ar(64'h3000, 8'd1); push_beats(64'h3000, 2);
    start_xfer(64'h3000, 32'd128, 1'b1);
    wait_done(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
